// File: rtl/prom_arbiter.sv
// Round-robin arbiter sharing one pROM read port between fetch (F) and data (D).
// A {valid, port} tag rides a ROM_LAT-deep pipeline so each returned word is routed to its requester.
module prom_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1,
  parameter int FIRST_F = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout
);

  typedef enum logic {TOK_F = 1'b0, TOK_D = 1'b1} tok_e;
  typedef struct packed {
    logic vld;
    logic port;   // 0 = F, 1 = D
  } tag_t;

  localparam tok_e TOK_RST = (FIRST_F != 0) ? TOK_F : TOK_D;

  tok_e tok, tok_nxt;
  tag_t tag_pipe [ROM_LAT];
  tag_t tag_out;
  logic both;

  always_ff @(posedge clk) begin
    if (reset) tok <= TOK_RST;
    else       tok <= tok_nxt;
  end

  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    tok_nxt = tok;
    both    = f_req & d_req;
    if (!reset) begin
      f_gnt = f_req & (~d_req | (tok == TOK_F));
      d_gnt = d_req & (~f_req | (tok == TOK_D));
      // on contention the token passes to whichever side lost
      if (both) tok_nxt = f_gnt ? TOK_D : TOK_F;
    end
  end

  assign rom_ad    = d_gnt ? d_addr : f_addr;
  assign rom_ce    = f_gnt | d_gnt;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_t'{rom_ce, d_gnt};
      for (int i = 1; i < ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out  = tag_pipe[ROM_LAT-1];
  // masked during reset so a tag loaded before the reset edge never surfaces
  assign f_rvalid = tag_out.vld & ~tag_out.port & ~reset;
  assign d_rvalid = tag_out.vld &  tag_out.port & ~reset;
  assign f_rdata  = rom_dout;
  assign d_rdata  = rom_dout;

endmodule

// File: tb/tb_prom_arbiter.sv
// Bench for prom_arbiter: pROM model, queue-based return model, directed cases and random traffic.
module tb_prom_arbiter;
  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int FF  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req;
  logic [AW-1:0] f_addr, d_addr;
  logic          f_gnt, d_gnt, f_rvalid, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata, rom_dout;
  logic [AW-1:0] rom_ad;
  logic          rom_ce, rom_oce, rom_reset;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .FIRST_F(FF)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_dout(rom_dout)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {a, 3'b011} ^ {a[2:0], a};
  endfunction

  // pROM: address register loads only with ce; later stages always advance
  logic [DW-1:0] rs0 = '0, rs1 = '0;
  always @(posedge clk) begin
    if (rom_ce) rs0 <= word(rom_ad);
    rs1 <= rs0;
  end
  assign rom_dout = (LAT == 1) ? rs0 : rs1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            due;
    bit            d;
    logic [AW-1:0] addr;
  } ret_t;

  ret_t q[$];
  bit   tok_f = (FF != 0);
  int   cyc = 0;
  int   fw = 0, dw = 0;
  bit   last_f_gnt = 0, last_d_gnt = 0;

  always @(negedge clk) begin : cmp
    bit ef, ed, ev_f, ev_d;
    logic [AW-1:0] ea;
    ef = !reset && f_req && (!d_req || tok_f);
    ed = !reset && d_req && (!f_req || !tok_f);
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("rom_ce", 32'(rom_ce), 32'(ef | ed));
    chk("rom_ad", 32'(rom_ad), 32'(ed ? d_addr : f_addr));
    chk("rom_reset", 32'(rom_reset), 32'(reset));
    ev_f = 0; ev_d = 0; ea = '0;
    if (!reset && q.size() != 0 && q[0].due == cyc) begin
      ev_f = !q[0].d;
      ev_d = q[0].d;
      ea   = q[0].addr;
      void'(q.pop_front());
    end
    chk("f_rvalid", 32'(f_rvalid), 32'(ev_f));
    chk("d_rvalid", 32'(d_rvalid), 32'(ev_d));
    if (ev_f) chk("f_rdata", 32'(f_rdata), 32'(word(ea)));
    if (ev_d) chk("d_rdata", 32'(d_rdata), 32'(word(ea)));
    if (reset) begin
      q.delete();
      tok_f = (FF != 0);
      fw = 0;
      dw = 0;
    end else begin
      if (ef || ed) q.push_back('{cyc + LAT, ed, ed ? d_addr : f_addr});
      if (f_req && d_req) tok_f = ed;
      fw = (f_req && d_req && !f_gnt) ? fw + 1 : 0;
      dw = (f_req && d_req && !d_gnt) ? dw + 1 : 0;
      chk("f_wait_le1", 32'(fw <= 1), 32'd1);
      chk("d_wait_le1", 32'(dw <= 1), 32'd1);
    end
    last_f_gnt = f_gnt;
    last_d_gnt = d_gnt;
    cyc++;
  end

  logic [DW-1:0] dout0;
  logic [5:0]    rr_pat;

  initial begin
    reset = 1; f_req = 0; d_req = 0; f_addr = '0; d_addr = '0;
    rr_pat = 6'b010101;
    repeat (3) step();
    @(negedge clk);
    chk("rst_oce", 32'(rom_oce), 32'd1);
    chk("rst_ce", 32'(rom_ce), 32'd0);
    chk("rst_rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
    step(); reset = 0;

    // lone fetch stream, full throughput
    for (int i = 0; i < 8; i++) begin
      f_req = 1; f_addr = AW'(i);
      if (i == 2) begin
        @(negedge clk);
        chk("t1_rvalid", 32'(f_rvalid), 32'd1);
        chk("t1_word0", 32'(f_rdata), 32'h0003);
      end
      step();
    end
    f_req = 0;

    // both requesting: strict alternation starting with F
    step(); reset = 1;
    step(); reset = 0;
    f_req = 1; d_req = 1; f_addr = 13'd100; d_addr = 13'd200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_f_gnt", 32'(f_gnt), 32'(rr_pat[i]));
      step();
    end
    f_req = 0; d_req = 0;

    // address wrap on the data port
    step(); d_req = 1; d_addr = 13'h1FFF;
    step(); d_addr = 13'h0000;
    step(); d_req = 0;
    @(negedge clk);
    chk("t3_rvalid0", 32'(d_rvalid), 32'd1);
    chk("t3_word1fff", 32'(d_rdata), 32'h0004);
    step();
    @(negedge clk);
    chk("t3_rvalid1", 32'(d_rvalid), 32'd1);
    chk("t3_word0000", 32'(d_rdata), 32'h0003);
    step();

    // reset right after a grant kills the in-flight return
    step(); f_req = 1; f_addr = 13'd55;
    step(); f_req = 0; reset = 1;
    step(); reset = 0;
    @(negedge clk);
    chk("t4_no_rvalid", 32'(f_rvalid), 32'd0);
    chk("t4_ce_idle", 32'(rom_ce), 32'd0);
    step(); step();
    f_req = 1; d_req = 1; f_addr = 13'd7; d_addr = 13'd9;
    @(negedge clk);
    chk("t4_token_f", 32'(f_gnt), 32'd1);
    step(); f_req = 0; d_req = 0;

    // idle
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) dout0 = rom_dout;
      chk("t5_ce", 32'(rom_ce), 32'd0);
      chk("t5_rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
      chk("t5_dout_stable", 32'(rom_dout), 32'(dout0));
      step();
    end

    // random traffic with occasional resets and withdrawals
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (f_req && !last_f_gnt) begin
        if ($urandom_range(0, 19) == 0) f_req = 0;
      end else begin
        f_req  = ($urandom_range(0, 99) < 55);
        f_addr = AW'($urandom);
      end
      if (d_req && !last_d_gnt) begin
        if ($urandom_range(0, 19) == 0) d_req = 0;
      end else begin
        d_req  = ($urandom_range(0, 99) < 55);
        d_addr = AW'($urandom);
      end
      step();
    end
    reset = 0; f_req = 0; d_req = 0;
    repeat (LAT + 3) step();
    @(negedge clk);
    chk("drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
